// File: rtl/hamming_serial_tx.sv
// Serial Hamming(7,4) transmitter: buffers one 4-bit word, encodes it and shifts the
// codeword out position 1 first, with a strobe on every bit and GAP idle cycles per frame.
module hamming_serial_tx #(
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:4]       data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             strobe_out,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  localparam logic [3:0] GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_e           state_q;
  logic [1:4]       hold_q;
  logic             hold_vld_q;
  logic [5:0]       shift_q;
  logic [2:0]       bit_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             data_out_q;
  logic             strobe_q;

  logic       accept;
  logic       send_last;
  logic       load;
  logic [6:0] cw;

  // Bit 0 holds codeword position 1 so the frame shifts out LSB first.
  function automatic logic [6:0] encode(input logic [1:4] d);
    logic p1, p2, p4;
    p1 = d[1] ^ d[2] ^ d[4];
    p2 = d[1] ^ d[3] ^ d[4];
    p4 = d[2] ^ d[3] ^ d[4];
    return {d[4], d[3], d[2], p4, d[1], p2, p1};
  endfunction

  always_comb begin
    cw        = encode(hold_q);
    accept    = valid_in && !hold_vld_q;
    send_last = (state_q == StSend) && (bit_cnt_q == 3'd6);
    load      = hold_vld_q && ((state_q == StIdle) ||
                               (send_last && (GAP == 0)) ||
                               ((state_q == StGap) && (gap_cnt_q == 4'd0)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      data_out_q  <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      // accept and load are exclusive: accept needs an empty holding register, load a full one.
      if (accept) begin
        hold_q     <= data_in;
        hold_vld_q <= 1'b1;
      end else if (load) begin
        hold_vld_q <= 1'b0;
      end

      if (send_last) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end

      if (load) begin
        state_q    <= StSend;
        shift_q    <= cw[6:1];
        data_out_q <= cw[0];
        strobe_q   <= 1'b1;
        bit_cnt_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            data_out_q <= 1'b0;
            strobe_q   <= 1'b0;
          end
          StSend: begin
            if (send_last) begin
              data_out_q <= 1'b0;
              strobe_q   <= 1'b0;
              if (GAP > 0) begin
                state_q   <= StGap;
                gap_cnt_q <= GapLast;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              data_out_q <= shift_q[0];
              shift_q    <= {1'b0, shift_q[5:1]};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
            end
          end
          StGap: begin
            if (gap_cnt_q == 4'd0) begin
              state_q <= StIdle;
            end else begin
              gap_cnt_q <= gap_cnt_q - 4'd1;
            end
          end
          default: begin
            state_q    <= StIdle;
            data_out_q <= 1'b0;
            strobe_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_out  = !hold_vld_q;
  assign busy       = (state_q != StIdle) || hold_vld_q;
  assign data_out   = data_out_q;
  assign strobe_out = strobe_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Bench for hamming_serial_tx: instance a (GAP=1, CNT_W=8) and instance b (GAP=0, CNT_W=2),
// expected codewords queued at accept time and popped by a serial-line monitor.
module tb_hamming_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:4] din_a, din_b;
  logic       vld_a, vld_b, rdy_a, rdy_b, dout_a, dout_b, stb_a, stb_b, busy_a, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  hamming_serial_tx #(.GAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .data_in(din_a), .valid_in(vld_a), .ready_out(rdy_a),
    .data_out(dout_a), .strobe_out(stb_a), .busy(busy_a), .frame_cnt(cnt_a)
  );

  hamming_serial_tx #(.GAP(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data_in(din_b), .valid_in(vld_b), .ready_out(rdy_b),
    .data_out(dout_b), .strobe_out(stb_b), .busy(busy_b), .frame_cnt(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] q_a[$];
  logic [6:0] q_b[$];

  // Hand-encoded codewords indexed by {d1,d2,d3,d4}; MSB is position 1 (first on the line).
  logic [6:0] cw_tab[16] = '{
    7'b0000000, 7'b1101001, 7'b0101010, 7'b1000011,
    7'b1001100, 7'b0100101, 7'b1100110, 7'b0001111,
    7'b1110000, 7'b0011001, 7'b1011010, 7'b0110011,
    7'b0111100, 7'b1010101, 7'b0010110, 7'b1111111
  };
  logic [1:0] cnt_seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s got timeout expected event", name);
  endtask

  task automatic set_in(input int ch, input logic v, input logic [3:0] d);
    if (ch == 0) begin vld_a = v; din_a = d; end
    else begin vld_b = v; din_b = d; end
  endtask

  task automatic push_exp(input int ch, input logic [3:0] w);
    if (ch == 0) q_a.push_back(cw_tab[w]);
    else q_b.push_back(cw_tab[w]);
  endtask

  function automatic logic rdy(input int ch);
    return (ch == 0) ? rdy_a : rdy_b;
  endfunction

  task automatic pop_check(input int ch, input logic [6:0] got);
    logic [6:0] exp;
    if ((ch == 0 && q_a.size() == 0) || (ch == 1 && q_b.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL frame_%0d got %b expected no frame", ch, got);
    end else begin
      exp = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
      check((ch == 0) ? "frame_a" : "frame_b", {25'd0, got}, {25'd0, exp});
    end
  endtask

  // Monitor: assemble 7 strobed bits per frame and compare against the queue head.
  logic [6:0] sr_a, sr_b;
  int n_a = 0;
  int n_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      n_a = 0;
      n_b = 0;
    end else begin
      if (stb_a) begin
        sr_a = {sr_a[5:0], dout_a};
        n_a++;
        if (n_a == 7) begin n_a = 0; pop_check(0, sr_a); end
      end else check("idle_data_a", {31'd0, dout_a}, 32'd0);
      if (stb_b) begin
        sr_b = {sr_b[5:0], dout_b};
        n_b++;
        if (n_b == 7) begin n_b = 0; pop_check(1, sr_b); end
      end else check("idle_data_b", {31'd0, dout_b}, 32'd0);
    end
  end

  // Call away from a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input int ch, input logic [3:0] w);
    logic acc;
    logic done = 1'b0;
    set_in(ch, 1'b1, w);
    for (int t = 0; t < 50 && !done; t++) begin
      acc = rdy(ch);
      @(posedge clk);
      #1;
      if (acc) begin push_exp(ch, w); done = 1'b1; end
    end
    set_in(ch, 1'b0, w);
    if (!done) timeout("send_accept");
  endtask

  task automatic wait_idle(input int ch);
    logic done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (!((ch == 0) ? busy_a : busy_b)) done = 1'b1;
    end
    if (!done) timeout("wait_idle");
  endtask

  // Hold valid high across n words; record strobe each cycle starting after the first accept.
  task automatic burst(input int ch, input int n, input logic [15:0] words, input int ncyc,
                       output logic [31:0] pat);
    int idx = 0;
    logic acc, v;
    logic [3:0] wd;
    wd = words[15 -: 4];
    v = 1'b1;
    set_in(ch, v, wd);
    for (int t = 0; t < 50 && idx == 0; t++) begin
      acc = rdy(ch);
      @(posedge clk);
      #1;
      if (acc) begin push_exp(ch, wd); idx = 1; end
    end
    if (idx == 0) timeout("burst_first_accept");
    if (idx < n) wd = words[15 - 4 * idx -: 4];
    else v = 1'b0;
    set_in(ch, v, wd);
    pat = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      pat = {pat[30:0], (ch == 0) ? stb_a : stb_b};
      if (i == 0) check("ready_drop", {31'd0, rdy(ch)}, 32'd0);
      acc = v && rdy(ch);
      @(posedge clk);
      #1;
      if (acc) begin
        push_exp(ch, wd);
        idx++;
        if (idx < n) wd = words[15 - 4 * idx -: 4];
        else v = 1'b0;
        set_in(ch, v, wd);
      end
    end
    check("burst_accepts", idx, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    int highs;
    vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;

    // Reset values, during and after reset
    #3;
    check("rst_ready", {31'd0, rdy_a}, 32'd1);
    check("rst_strobe", {31'd0, stb_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    #19 rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, rdy_a}, 32'd1);
    check("post_rst_data", {31'd0, dout_a}, 32'd0);
    check("post_rst_cnt_a", {24'd0, cnt_a}, 32'd0);
    check("post_rst_cnt_b", {30'd0, cnt_b}, 32'd0);

    // Single word 1011: one-cycle latency, 7 strobes, one gap cycle, then idle
    burst(0, 1, 16'hB000, 10, pat);
    check("single_strobe_pattern", {22'd0, pat[9:0]}, {22'd0, 10'b0111111100});
    wait_idle(0);
    check("single_cnt", {24'd0, cnt_a}, 32'd1);
    check("single_busy", {31'd0, busy_a}, 32'd0);

    // All-zero and all-one words, then every word back to back
    send(0, 4'b0000);
    send(0, 4'b1111);
    wait_idle(0);
    check("extreme_cnt", {24'd0, cnt_a}, 32'd3);
    for (int w = 0; w < 16; w++) send(0, 4'(w));
    wait_idle(0);
    check("sweep_cnt", {24'd0, cnt_a}, 32'd19);

    // Three words with valid held, GAP=1: 7 high / 1 low, three times, no extra idle
    burst(0, 3, 16'h5A3_0, 26, pat);
    check("burst3_pattern", {6'd0, pat[25:0]}, {6'd0, 26'b01111111011111110111111100});
    wait_idle(0);
    check("burst3_cnt", {24'd0, cnt_a}, 32'd22);

    // GAP=0: two words give 14 continuous strobe cycles
    burst(1, 2, 16'hB6_00, 17, pat);
    check("gap0_pattern", {15'd0, pat[16:0]}, {15'd0, 17'b01111111111111100});
    wait_idle(1);
    check("gap0_cnt", {30'd0, cnt_b}, 32'd2);

    // Reset during bit 4 with a second word held
    send(0, 4'b1100);
    send(0, 4'b0011);
    check("hold_busy", {31'd0, busy_a}, 32'd1);
    check("hold_ready", {31'd0, rdy_a}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bit4_strobe", {31'd0, stb_a}, 32'd1);
    #2 rst = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    check("abort_strobe", {31'd0, stb_a}, 32'd0);
    check("abort_data", {31'd0, dout_a}, 32'd0);
    check("abort_ready", {31'd0, rdy_a}, 32'd1);
    check("abort_busy", {31'd0, busy_a}, 32'd0);
    check("abort_cnt", {24'd0, cnt_a}, 32'd0);
    #20 rst = 1'b1;
    @(negedge clk);
    check("release_ready", {31'd0, rdy_a}, 32'd1);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stb_a) highs++;
    end
    check("no_frame_after_abort", highs, 0);
    check("release_busy", {31'd0, busy_a}, 32'd0);

    // CNT_W=2 counter wrap
    for (int i = 0; i < 5; i++) begin
      send(1, 4'(i + 3));
      wait_idle(1);
      check("wrap_cnt", {30'd0, cnt_b}, {30'd0, cnt_seq[i]});
    end

    repeat (3) @(negedge clk);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
